spectrum_peak_picker: RTL
=========================

# spectrum_peak_picker

Per-frame band-maximum finder feeding the peak serializer. Consumes one FFT magnitude frame (FFT_BINS bins, one bin per accepted sample) and, for each of MAXIMAS_COUNT fixed frequency bands, finds the bin index with the largest magnitude. At frame end it presents all band peak indices in parallel and pulses `peaks_valid`, which drives the serializer's `load` directly.

## Interface
- MAXIMAS_COUNT, 11, number of bands and peak outputs.
- MAG_WIDTH, 16, magnitude sample width, unsigned.
- FFT_BINS, 512, bins per frame; index width fixed at 9 bits.
- MIN_MAG, 64, magnitude floor; used only with PEAK_THRESHOLD_EN.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- mag_valid  in  1  `mag_data` carries one bin this cycle.
- mag_data  in  MAG_WIDTH  bin magnitude, bins in ascending order.
- frame_start  in  1  qualified by `mag_valid`; marks bin 0.
- peak_bin  out  [8:0] x MAXIMAS_COUNT  peak bin index per band; 0 means no peak.
- peaks_valid  out  1  one-cycle pulse; `peak_bin` is new.
- frame_error  out  1  one-cycle pulse; frame aborted or dropped.

## Operation
- Bands are half-open [BAND_EDGE[k], BAND_EDGE[k+1]) with BAND_EDGE = 1, 8, 16, 24, 40, 64, 96, 128, 176, 240, 336, 512.
- Bin 0 (DC) belongs to no band, so 0 is an unambiguous "no peak" code.
- States: S_IDLE, S_ACC, S_EMIT.
- S_IDLE:
  - `mag_valid` without `frame_start` is ignored.
  - `mag_valid && frame_start` accepts that sample as bin 0, clears the tracker, sets band = 0, and enters S_ACC.
- S_ACC: each `mag_valid` advances bin_cnt by 1. Cycles without `mag_valid` hold all state.
- Tracker update rule:
  - Update when `mag_data > best_mag` (strict). Ties keep the lowest bin.
  - Tracker initial value is best_mag = 0, best_bin = 0. A band of all-zero magnitudes therefore reports 0.
- Band advance: on the accepted bin b == BAND_EDGE[k+1]-1, commit the tracker result (including b) to acc[k], clear the tracker, and set k = k+1.
- Frame end: the accepted bin FFT_BINS-1 commits the last band and moves the state to S_EMIT.
- S_EMIT: for one cycle, copy `peak_bin` <= acc and pulse `peaks_valid`, then return to S_IDLE.
- `frame_start` with `mag_valid` in S_ACC:
  - Pulse `frame_error` and discard the partial frame; outputs are unchanged.
  - Restart accumulation with that sample as bin 0.
- `frame_start` with `mag_valid` in S_EMIT:
  - Pulse `frame_error` and drop that sample; the emit still completes.
  - Return to S_IDLE; the block resyncs on the next `frame_start`.
- `peak_bin` holds its value until the next `peaks_valid`.
- Reset, including mid-frame:
  - State S_IDLE; tracker, acc and bin_cnt cleared.
  - `peak_bin` all 0, `peaks_valid` 0, `frame_error` 0.
  - Any partial frame is discarded.

## Timing
- Last bin accepted in cycle N: state is S_EMIT in N+1, and `peaks_valid`/`peak_bin` are visible in N+2.
- `peaks_valid` is high exactly one cycle per completed frame.
- `frame_error` is registered and visible the cycle after the offending sample.
- Full-rate input (`mag_valid` every cycle) is supported.
- Upstream must leave at least 2 idle cycles between the last bin and the next `frame_start`.
- The serializer drains in MAXIMAS_COUNT+1 cycles, far below one frame time, so no backpressure port exists.

## Configuration
- PEAK_THRESHOLD_EN defined:
  - Samples with `mag_data < MIN_MAG` never update the tracker.
  - A band with no qualifying sample reports 0.
- PEAK_THRESHOLD_EN undefined: all samples qualify and MIN_MAG is unused.

## Structure
- Shared package `shazam_pkg` holds:
  - MAXIMAS_COUNT default;
  - BAND_EDGE constant array;
  - bin index width (9);
  - state enum `picker_state_t`.
- One sub-module, `band_max_tracker`. It holds the running max and argmax of the current band. Its controls are `clear` and `sample_en`, plus the bin/mag inputs, and it outputs `best_bin`/`best_mag`. The threshold gate lives inside it.

## Test plan
- Single spike: zero frame with bin 30 = 1000 -> `peak_bin[3]` = 30, all others 0. `peaks_valid` is one cycle, 2 cycles after bin 511.
- Tie: bins 64 and 70 both 500, rest 0 -> `peak_bin[5]` = 64.
- Ramp `mag_data` = bin index -> `peak_bin` = 7, 15, 23, 39, 63, 95, 127, 175, 239, 335, 511. Repeat with random `mag_valid` gaps -> identical result.
- `frame_start` re-asserted at bin 200 -> `frame_error` pulses and there is no `peaks_valid`. A full ramp frame then starts from that sample -> ramp result.
- Reset pulsed at bin 300 -> all outputs 0 and no `peaks_valid`. A following spike frame reports correctly.
- Band 2 max = 63 at bin 20:
  - with PEAK_THRESHOLD_EN -> `peak_bin[2]` = 0;
  - without PEAK_THRESHOLD_EN -> `peak_bin[2]` = 20.

Source files
------------

// File: rtl/shazam_pkg.sv
// shazam_pkg: shared constants, band edges and picker state encoding for the peak-picking path.
package shazam_pkg;
   localparam int MAXIMAS_COUNT = 11;
   localparam int BIN_W = 9;
   localparam int MAG_W = 16;
   localparam int FFT_BINS = 512;
   localparam int MIN_MAG = 64;
   localparam logic [BIN_W:0] BAND_EDGE [0:11] = '{
      10'd1, 10'd8, 10'd16, 10'd24, 10'd40, 10'd64,
      10'd96, 10'd128, 10'd176, 10'd240, 10'd336, 10'd512
   };
   typedef enum logic [1:0] {S_IDLE, S_ACC, S_EMIT} picker_state_t;
   function automatic logic [BIN_W-1:0] band_last(input logic [3:0] k);
      return BIN_W'(BAND_EDGE[k + 4'd1] - 10'd1);
   endfunction
endpackage

// File: rtl/band_max_tracker.sv
// band_max_tracker: running max/argmax of the current band; PEAK_THRESHOLD_EN gates samples below MIN_MAG.
module band_max_tracker
   import shazam_pkg::*;
#(
   parameter int MAG_WIDTH = MAG_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 sample_en,
   input  logic [BIN_W-1:0]     bin,
   input  logic [MAG_WIDTH-1:0] mag,
   output logic [BIN_W-1:0]     best_bin,
   output logic [MAG_WIDTH-1:0] best_mag
);
   logic [BIN_W-1:0] best_bin_q;
   logic [MAG_WIDTH-1:0] best_mag_q;
   logic qual, upd;
`ifdef PEAK_THRESHOLD_EN
   assign qual = mag >= MAG_WIDTH'(MIN_MAG);
`else
   assign qual = 1'b1;
`endif
   assign upd = sample_en && qual && (mag > best_mag_q);
   // Outputs include the sample presented this cycle so a band can commit on its last bin.
   assign best_bin = upd ? bin : best_bin_q;
   assign best_mag = upd ? mag : best_mag_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         best_bin_q <= '0;
         best_mag_q <= '0;
      end else if (clear) begin
         best_bin_q <= '0;
         best_mag_q <= '0;
      end else if (upd) begin
         best_bin_q <= bin;
         best_mag_q <= mag;
      end
   end
endmodule

// File: rtl/spectrum_peak_picker.sv
// spectrum_peak_picker: per-frame band argmax finder presenting all band peaks at frame end.
// Optional magnitude floor enabled by defining PEAK_THRESHOLD_EN.
module spectrum_peak_picker
   import shazam_pkg::*;
#(
   parameter int MAXIMAS_COUNT = shazam_pkg::MAXIMAS_COUNT,
   parameter int MAG_WIDTH = shazam_pkg::MAG_W,
   parameter int FFT_BINS = shazam_pkg::FFT_BINS
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  mag_valid,
   input  logic [MAG_WIDTH-1:0]                  mag_data,
   input  logic                                  frame_start,
   output logic [MAXIMAS_COUNT-1:0][BIN_W-1:0]   peak_bin,
   output logic                                  peaks_valid,
   output logic                                  frame_error
);
   picker_state_t state_q, state_d;
   logic [BIN_W-1:0] bin_cnt_q, bin_cnt_d;
   logic [3:0] band_q, band_d;
   logic [MAXIMAS_COUNT-1:0][BIN_W-1:0] acc_q, acc_d, peak_bin_q, peak_bin_d;
   logic peaks_valid_q, peaks_valid_d, frame_error_q, frame_error_d;
   logic clear, sample_en;
   logic [BIN_W-1:0] best_bin, commit_bin;
   logic [MAG_WIDTH-1:0] best_mag;

   band_max_tracker #(.MAG_WIDTH(MAG_WIDTH)) u_tracker (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .sample_en(sample_en),
      .bin      (bin_cnt_q),
      .mag      (mag_data),
      .best_bin (best_bin),
      .best_mag (best_mag)
   );

   assign commit_bin = (best_mag != '0) ? best_bin : '0;

   always_comb begin
      state_d = state_q;
      bin_cnt_d = bin_cnt_q;
      band_d = band_q;
      acc_d = acc_q;
      peak_bin_d = peak_bin_q;
      peaks_valid_d = 1'b0;
      frame_error_d = 1'b0;
      clear = 1'b0;
      sample_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mag_valid && frame_start) begin
               state_d = S_ACC;
               bin_cnt_d = 9'd1;
               band_d = '0;
               clear = 1'b1;
            end
         end
         S_ACC: begin
            if (mag_valid && frame_start) begin
               // Restart: this sample becomes bin 0 of a fresh frame.
               frame_error_d = 1'b1;
               bin_cnt_d = 9'd1;
               band_d = '0;
               clear = 1'b1;
            end else if (mag_valid) begin
               sample_en = 1'b1;
               bin_cnt_d = bin_cnt_q + 9'd1;
               if (bin_cnt_q == band_last(band_q)) begin
                  acc_d[band_q] = commit_bin;
                  clear = 1'b1;
                  band_d = band_q + 4'd1;
               end
               if (bin_cnt_q == BIN_W'(FFT_BINS - 1))
                  state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            peak_bin_d = acc_q;
            peaks_valid_d = 1'b1;
            frame_error_d = mag_valid && frame_start;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         bin_cnt_q <= '0;
         band_q <= '0;
         acc_q <= '0;
         peak_bin_q <= '0;
         peaks_valid_q <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_cnt_q <= bin_cnt_d;
         band_q <= band_d;
         acc_q <= acc_d;
         peak_bin_q <= peak_bin_d;
         peaks_valid_q <= peaks_valid_d;
         frame_error_q <= frame_error_d;
      end
   end

   assign peak_bin = peak_bin_q;
   assign peaks_valid = peaks_valid_q;
   assign frame_error = frame_error_q;
endmodule
